sprite_layer_mixer: RTL

//  Per-pixel compositor between the VGA timing driver and the sprite/background

---
 rtl/sprite_layer_mixer_pkg.sv | 20 ++
 rtl/sprite_layer_mixer_if.sv | 37 +++
 rtl/sprite_layer_mixer_window.sv | 79 +++++++
 rtl/sprite_layer_mixer.sv | 139 +++++++++++++
 4 files changed

// File: rtl/sprite_layer_mixer_pkg.sv
// Shared types and constants for the sprite layer mixer.
// Game-state encoding matches the game controller.
package sprite_layer_mixer_pkg;

  typedef enum logic [1:0] {
    GAME_INITIAL = 2'b00,
    GAME_RUNNING = 2'b01,
    GAME_OVER    = 2'b10,
    GAME_SUCCESS = 2'b11
  } game_state_t;

  localparam logic [11:0] INIT_COLOR    = 12'hF00;
  localparam logic [11:0] SUCCESS_COLOR = 12'h00F;

  localparam int DEF_NUM_SPRITES = 4;
  localparam int DEF_X_W         = 10;
  localparam int DEF_Y_W         = 9;
  localparam int DEF_COLOR_W     = 12;

endpackage

// File: rtl/sprite_layer_mixer_if.sv
// Pixel bus between VGA timing/image ROMs (master) and the mixer (slave).
// Carries coordinates, sprite state, ROM fetch/return and composited output.
interface sprite_layer_mixer_if #(
  parameter int NUM_SPRITES = 4,
  parameter int X_W         = 10,
  parameter int Y_W         = 9,
  parameter int COLOR_W     = 12
);

  logic                           pix_en;
  logic [X_W-1:0]                 x;
  logic [Y_W-1:0]                 y;
  logic                           frame_start;
  logic [1:0]                     game_state;
  logic [NUM_SPRITES-1:0]         spr_en;
  logic [NUM_SPRITES*X_W-1:0]     spr_x;
  logic [NUM_SPRITES*Y_W-1:0]     spr_y;
  logic [NUM_SPRITES*X_W-1:0]     spr_rel_x;
  logic [NUM_SPRITES*Y_W-1:0]     spr_rel_y;
  logic [NUM_SPRITES*COLOR_W-1:0] spr_color;
  logic [COLOR_W-1:0]             bg_color;
  logic [COLOR_W-1:0]             vga_data;
  logic [NUM_SPRITES-1:0]         collide;

  modport master (
    output pix_en, x, y, frame_start, game_state,
    output spr_en, spr_x, spr_y, spr_color, bg_color,
    input  spr_rel_x, spr_rel_y, vga_data, collide
  );

  modport slave (
    input  pix_en, x, y, frame_start, game_state,
    input  spr_en, spr_x, spr_y, spr_color, bg_color,
    output spr_rel_x, spr_rel_y, vga_data, collide
  );

endinterface

// File: rtl/sprite_layer_mixer_window.sv
// One sprite channel: shadowed position, window hit test,
// ROM fetch coordinates and hit delay matched to ROM latency.
module sprite_window #(
  parameter int X_W     = 10,
  parameter int Y_W     = 9,
  parameter int SPR_W   = 60,
  parameter int SPR_H   = 80,
  parameter int ROM_LAT = 1
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_pix_en,
  input  logic           i_frame_start,
  input  logic           i_en,
  input  logic [X_W-1:0] i_sx,
  input  logic [Y_W-1:0] i_sy,
  input  logic [X_W-1:0] i_x,
  input  logic [Y_W-1:0] i_y,
  output logic [X_W-1:0] o_rel_x,
  output logic [Y_W-1:0] o_rel_y,
  output logic           o_hit
);

  localparam int XS = X_W + 2;
  localparam int YS = Y_W + 2;
  localparam logic [XS-1:0] HALF_W = XS'(SPR_W / 2);
  localparam logic [YS-1:0] HALF_H = YS'(SPR_H / 2);
  localparam logic [XS-1:0] LIM_W  = XS'(SPR_W);
  localparam logic [YS-1:0] LIM_H  = YS'(SPR_H);

  logic           r_en;
  logic [X_W-1:0] r_sx;
  logic [Y_W-1:0] r_sy;
  logic [X_W-1:0] r_rel_x;
  logic [Y_W-1:0] r_rel_y;
  logic [ROM_LAT:0] r_hit;

  logic [XS-1:0] w_rx;
  logic [YS-1:0] w_ry;
  logic          w_in_x;
  logic          w_in_y;
  logic          w_hit;

  // Two guard bits: the MSB flags a negative offset, so no wrap can alias a hit.
  assign w_rx   = {2'b00, i_x} - {2'b00, r_sx} + HALF_W;
  assign w_ry   = {2'b00, i_y} - {2'b00, r_sy} + HALF_H;
  assign w_in_x = ~w_rx[XS-1] & (w_rx < LIM_W);
  assign w_in_y = ~w_ry[YS-1] & (w_ry < LIM_H);
  assign w_hit  = r_en & w_in_x & w_in_y;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_en <= 1'b0;
      r_sx <= '0;
      r_sy <= '0;
    end else if (i_frame_start) begin
      r_en <= i_en;
      r_sx <= i_sx;
      r_sy <= i_sy;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rel_x <= '0;
      r_rel_y <= '0;
      r_hit   <= '0;
    end else if (i_pix_en) begin
      r_rel_x <= w_hit ? w_rx[X_W-1:0] : '0;
      r_rel_y <= w_hit ? w_ry[Y_W-1:0] : '0;
      r_hit   <= {r_hit[ROM_LAT-1:0], w_hit};
    end
  end

  assign o_rel_x = r_rel_x;
  assign o_rel_y = r_rel_y;
  assign o_hit   = r_hit[ROM_LAT];

endmodule

// File: rtl/sprite_layer_mixer.sv
// Sprite/background compositor with frame-shadowed state and priority mux.
// Optional sticky sprite-0 collision flags under `define MIXER_COLLISION_EN.
module sprite_layer_mixer
  import sprite_layer_mixer_pkg::*;
#(
  parameter int               NUM_SPRITES = DEF_NUM_SPRITES,
  parameter int               SPR_W       = 60,
  parameter int               SPR_H       = 80,
  parameter int               X_W         = DEF_X_W,
  parameter int               Y_W         = DEF_Y_W,
  parameter int               COLOR_W     = DEF_COLOR_W,
  parameter int               ROM_LAT     = 1,
  parameter logic [COLOR_W-1:0] TRANSP_KEY = '0
) (
  input logic                i_clk,
  input logic                i_rst,
  sprite_layer_mixer_if.slave bus
);

  game_state_t r_state;
  logic [ROM_LAT-1:0][COLOR_W-1:0] r_bg_dly;
  logic [COLOR_W-1:0] r_vga;

  logic [NUM_SPRITES-1:0][X_W-1:0]     w_rel_x;
  logic [NUM_SPRITES-1:0][Y_W-1:0]     w_rel_y;
  logic [NUM_SPRITES-1:0][COLOR_W-1:0] w_col;
  logic [NUM_SPRITES-1:0]              w_hit;
  logic [NUM_SPRITES-1:0]              w_opq;
  logic [COLOR_W-1:0]                  w_bg;
  logic [COLOR_W-1:0]                  w_spr;
  logic [COLOR_W-1:0]                  w_pix;

  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_win
    sprite_window #(
      .X_W     (X_W),
      .Y_W     (Y_W),
      .SPR_W   (SPR_W),
      .SPR_H   (SPR_H),
      .ROM_LAT (ROM_LAT)
    ) u_win (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_pix_en      (bus.pix_en),
      .i_frame_start (bus.frame_start),
      .i_en          (bus.spr_en[g]),
      .i_sx          (bus.spr_x[g*X_W +: X_W]),
      .i_sy          (bus.spr_y[g*Y_W +: Y_W]),
      .i_x           (bus.x),
      .i_y           (bus.y),
      .o_rel_x       (w_rel_x[g]),
      .o_rel_y       (w_rel_y[g]),
      .o_hit         (w_hit[g])
    );
    assign w_opq[g] = w_hit[g] & (w_col[g] != TRANSP_KEY);
  end

  assign bus.spr_rel_x = w_rel_x;
  assign bus.spr_rel_y = w_rel_y;
  assign w_col         = bus.spr_color;
  assign w_bg          = r_bg_dly[ROM_LAT-1];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= GAME_INITIAL;
    end else if (bus.frame_start) begin
      r_state <= game_state_t'(bus.game_state);
    end
  end

  // Background arrives with the fetch coordinates; delay it to meet the ROMs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bg_dly <= '0;
    end else if (bus.pix_en) begin
      r_bg_dly[0] <= bus.bg_color;
      for (int k = 1; k < ROM_LAT; k++) begin
        r_bg_dly[k] <= r_bg_dly[k-1];
      end
    end
  end

  always_comb begin
    w_spr = w_bg;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (w_opq[i]) begin
        w_spr = w_col[i];
      end
    end
  end

  always_comb begin
    w_pix = w_bg;
    unique case (r_state)
      GAME_INITIAL: w_pix = COLOR_W'(INIT_COLOR);
      GAME_SUCCESS: w_pix = COLOR_W'(SUCCESS_COLOR);
      GAME_OVER:    w_pix = w_bg;
      GAME_RUNNING: w_pix = w_spr;
      default:      w_pix = w_bg;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vga <= '0;
    end else if (bus.pix_en) begin
      r_vga <= w_pix;
    end
  end

  assign bus.vga_data = r_vga;

`ifdef MIXER_COLLISION_EN
  logic [NUM_SPRITES-1:1] r_coll;
  logic [NUM_SPRITES-1:1] w_set;

  always_comb begin
    w_set = '0;
    for (int i = 1; i < NUM_SPRITES; i++) begin
      w_set[i] = bus.pix_en & w_opq[0] & w_opq[i];
    end
  end

  // A new collision on the frame boundary survives the clear.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_coll <= '0;
    end else if (bus.frame_start) begin
      r_coll <= w_set;
    end else begin
      r_coll <= r_coll | w_set;
    end
  end

  assign bus.collide = {r_coll, |r_coll};
`else
  assign bus.collide = '0;
`endif

endmodule
